// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_arb_pkg : shared state encoding and counter sizing for the arbiter
// rev 1.0
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Width of a counter that must hold every value in 0..max_count.
  function automatic int cnt_width(input int max_count);
    return $clog2(max_count) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_select.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_select : combinational round-robin pick, searching from last_ptr+1
// rev 1.0
// ---------------------------------------------------------------------------
module rr_select #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any_req
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  always_comb begin
    winner  = last_ptr;
    any_req = 1'b0;
    sum     = '0;
    idx     = '0;
    // Offset NUM_REQ wraps back to last_ptr itself, so it is searched last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, last_ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) begin
        sum = sum - (ID_W+1)'(NUM_REQ);
      end
      idx = sum[ID_W-1:0];
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_write_arbiter : round-robin packet arbiter feeding a ring-buffer write
// port, tracking downstream occupancy for back-pressure.  rev 1.0
// ---------------------------------------------------------------------------
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int BUFFER_SIZE = 32,
  parameter int MAX_PKT_LEN = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic                          fifo_valid,
  input  logic                          fifo_pop,
  output logic [$clog2(BUFFER_SIZE):0]  occupancy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          err_underflow,
  output logic                          err_trunc
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int OCC_W  = cnt_width(BUFFER_SIZE);
  localparam int BEAT_W = cnt_width(MAX_PKT_LEN);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic            err_underflow_q, err_underflow_d;
  logic            err_trunc_q, err_trunc_d;

  logic [ID_W-1:0]       rr_winner;
  logic                  rr_any;
  logic                  full;
  logic                  push;
  logic                  pop_ok;
  logic                  granted_valid;
  logic                  granted_last;
  logic [DATA_WIDTH-1:0] granted_data;
  logic [BEAT_W-1:0]     beat_inc;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_select (
    .req      (req_valid),
    .last_ptr (grant_id_q),
    .winner   (rr_winner),
    .any_req  (rr_any)
  );

  // One slot of the ring buffer is never usable, hence BUFFER_SIZE-1.
  assign full          = (occ_q == OCC_W'(BUFFER_SIZE - 1));
  assign granted_valid = req_valid[grant_id_q];
  assign granted_last  = req_last[grant_id_q];
  assign granted_data  = req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
  assign push          = fifo_valid;
  assign pop_ok        = fifo_pop && (occ_q != '0);
  assign beat_inc      = beat_q + BEAT_W'(1);

  always_comb begin
    req_ready  = '0;
    fifo_valid = 1'b0;
    fifo_data  = '0;
    busy       = 1'b0;
    if (!rst && state_q == GRANT) begin
      busy                  = 1'b1;
      req_ready[grant_id_q] = !full;
      fifo_valid            = granted_valid && !full;
      fifo_data             = granted_data;
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_id_d      = grant_id_q;
    occ_d           = occ_q;
    beat_d          = beat_q;
    err_underflow_d = err_underflow_q;
    err_trunc_d     = err_trunc_q;

    case ({push, pop_ok})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    if (fifo_pop && occ_q == '0) begin
      err_underflow_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (rr_any) begin
          grant_id_d = rr_winner;
          beat_d     = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (push) begin
          beat_d = beat_inc;
          if (granted_last) begin
            state_d = IDLE;
          end else if (beat_inc == BEAT_W'(MAX_PKT_LEN)) begin
            state_d     = IDLE;
            err_trunc_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      grant_id_q      <= ID_W'(NUM_REQ - 1);
      occ_q           <= '0;
      beat_q          <= '0;
      err_underflow_q <= 1'b0;
      err_trunc_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      grant_id_q      <= grant_id_d;
      occ_q           <= occ_d;
      beat_q          <= beat_d;
      err_underflow_q <= err_underflow_d;
      err_trunc_q     <= err_trunc_d;
    end
  end

  assign occupancy     = occ_q;
  assign grant_id      = grant_id_q;
  assign err_underflow = err_underflow_q;
  assign err_trunc     = err_trunc_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fifo_write_arbiter : directed self-checking bench for fifo_write_arbiter
// rev 1.0
// ---------------------------------------------------------------------------
module tb_fifo_write_arbiter;

  logic clk;
  logic rst;

  // Instance A: MAX_PKT_LEN 16.  Instance B: MAX_PKT_LEN 64 for the fill test.
  logic [31:0] a_req_data;
  logic [3:0]  a_req_valid, a_req_last, a_req_ready;
  logic [7:0]  a_fifo_data;
  logic        a_fifo_valid, a_fifo_pop;
  logic [5:0]  a_occ;
  logic [1:0]  a_grant_id;
  logic        a_busy, a_err_uf, a_err_tr;

  logic [31:0] b_req_data;
  logic [3:0]  b_req_valid, b_req_last, b_req_ready;
  logic [7:0]  b_fifo_data;
  logic        b_fifo_valid, b_fifo_pop;
  logic [5:0]  b_occ;
  logic [1:0]  b_grant_id;
  logic        b_busy, b_err_uf, b_err_tr;

  fifo_write_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(8), .BUFFER_SIZE(32), .MAX_PKT_LEN(16)
  ) u_dut_a (
    .clk(clk), .rst(rst),
    .req_data(a_req_data), .req_valid(a_req_valid), .req_last(a_req_last),
    .req_ready(a_req_ready), .fifo_data(a_fifo_data), .fifo_valid(a_fifo_valid),
    .fifo_pop(a_fifo_pop), .occupancy(a_occ), .grant_id(a_grant_id),
    .busy(a_busy), .err_underflow(a_err_uf), .err_trunc(a_err_tr)
  );

  fifo_write_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(8), .BUFFER_SIZE(32), .MAX_PKT_LEN(64)
  ) u_dut_b (
    .clk(clk), .rst(rst),
    .req_data(b_req_data), .req_valid(b_req_valid), .req_last(b_req_last),
    .req_ready(b_req_ready), .fifo_data(b_fifo_data), .fifo_valid(b_fifo_valid),
    .fifo_pop(b_fifo_pop), .occupancy(b_occ), .grant_id(b_grant_id),
    .busy(b_busy), .err_underflow(b_err_uf), .err_trunc(b_err_tr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Requester model for instance A: beats still to send, packet length, beats sent.
  int tot [4];
  int plen[4];
  int sent[4];
  bit lastmode[4];
  int cyc;
  logic [7:0] push_data[$];
  logic [1:0] push_gid[$];
  int         push_cyc[$];

  task automatic drive_a();
    for (int i = 0; i < 4; i++) begin
      a_req_valid[i]      = (tot[i] > 0);
      a_req_last[i]       = lastmode[i] && (((sent[i] + 1) % plen[i]) == 0);
      a_req_data[i*8 +: 8] = 8'(i*16 + (sent[i] % 16));
    end
  endtask

  task automatic clear_log();
    push_data.delete();
    push_gid.delete();
    push_cyc.delete();
    cyc = 0;
  endtask

  task automatic cyc_a();
    logic [3:0] hs;
    hs = a_req_ready & a_req_valid;
    if (a_fifo_valid) begin
      push_data.push_back(a_fifo_data);
      push_gid.push_back(a_grant_id);
      push_cyc.push_back(cyc);
    end
    @(posedge clk); #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (hs[i]) begin
        sent[i]++;
        tot[i]--;
      end
    end
    drive_a();
    #1;
  endtask

  int b_sent;
  int b_acc;

  task automatic drive_b();
    b_req_valid    = 4'b0000;
    b_req_last     = 4'b0000;
    b_req_data     = '0;
    b_req_valid[1] = (b_sent < 40);
    b_req_last[1]  = (b_sent == 39);
    b_req_data[15:8] = 8'(b_sent);
  endtask

  task automatic cyc_b();
    logic hs;
    hs = b_req_ready[1] & b_req_valid[1];
    @(posedge clk); #1;
    if (hs) begin
      b_sent++;
      b_acc++;
    end
    drive_b();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] exp_d1 [6];
  int         exp_c1 [6];
  logic [1:0] exp_g3 [5];
  int         exp_c3 [5];

  initial begin
    exp_d1 = '{8'h00, 8'h01, 8'h02, 8'h20, 8'h21, 8'h22};
    exp_c1 = '{1, 2, 3, 5, 6, 7};
    exp_g3 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_c3 = '{1, 3, 5, 7, 9};
    for (int i = 0; i < 4; i++) begin
      tot[i] = 0; plen[i] = 1; sent[i] = 0; lastmode[i] = 1'b1;
    end
    a_req_data = '0; a_req_valid = '0; a_req_last = '0; a_fifo_pop = 1'b0;
    b_sent = 0; b_acc = 0; b_fifo_pop = 1'b0;
    drive_b();
    b_req_valid = '0;
    clear_log();

    // Reset: outputs forced low during rst even with a request present.
    rst = 1'b1;
    drive_a();
    @(posedge clk); #1;
    @(posedge clk); #1;
    tot[0] = 1;
    drive_a();
    #1;
    check("rst_ready", a_req_ready, 0);
    check("rst_fifo_valid", a_fifo_valid, 0);
    check("rst_busy", a_busy, 0);
    rst = 1'b0;
    tot[0] = 0;
    drive_a();
    #1;
    check("rst_occ", a_occ, 0);
    check("rst_grant_id", a_grant_id, 3);
    check("rst_err_uf", a_err_uf, 0);
    check("rst_err_tr", a_err_tr, 0);

    // Requesters 0 and 2, 3-beat packets, no pops.
    tot[0] = 3; plen[0] = 3; tot[2] = 3; plen[2] = 3;
    drive_a();
    #1;
    for (int k = 0; k < 20 && (tot[0] > 0 || tot[2] > 0); k++) cyc_a();
    check("two_pkt_count", push_data.size(), 6);
    for (int j = 0; j < 6 && j < push_data.size(); j++) begin
      check($sformatf("two_pkt_data%0d", j), push_data[j], exp_d1[j]);
      check($sformatf("two_pkt_cyc%0d", j), push_cyc[j], exp_c1[j]);
    end
    check("two_pkt_occ", a_occ, 6);
    check("two_pkt_grant", a_grant_id, 2);

    // Push and pop together at occupancy 5, then underflow.
    a_fifo_pop = 1'b1;
    cyc_a();
    a_fifo_pop = 1'b0;
    check("pop_occ5", a_occ, 5);
    tot[1] = 1; plen[1] = 1;
    drive_a();
    #1;
    cyc_a();
    a_fifo_pop = 1'b1;
    cyc_a();
    a_fifo_pop = 1'b0;
    check("pushpop_occ", a_occ, 5);
    check("pushpop_grant", a_grant_id, 1);
    a_fifo_pop = 1'b1;
    repeat (5) cyc_a();
    check("drain_occ", a_occ, 0);
    check("drain_err_uf", a_err_uf, 0);
    cyc_a();
    a_fifo_pop = 1'b0;
    check("underflow_occ", a_occ, 0);
    check("underflow_err", a_err_uf, 1);

    // Reset in the middle of a packet from requester 1.
    for (int i = 0; i < 4; i++) sent[i] = 0;
    clear_log();
    tot[1] = 5; plen[1] = 5;
    drive_a();
    #1;
    repeat (3) cyc_a();
    check("midrst_beats", push_data.size(), 2);
    check("midrst_busy_before", a_busy, 1);
    rst = 1'b1;
    #1;
    check("midrst_ready", a_req_ready, 0);
    check("midrst_fifo_valid", a_fifo_valid, 0);
    check("midrst_fifo_data", a_fifo_data, 0);
    check("midrst_busy", a_busy, 0);
    cyc_a();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin tot[i] = 0; sent[i] = 0; end
    drive_a();
    #1;
    check("postrst_busy", a_busy, 0);
    check("postrst_occ", a_occ, 0);
    check("postrst_grant", a_grant_id, 3);
    check("postrst_err_uf", a_err_uf, 0);

    // All four requesters streaming 1-beat packets.
    clear_log();
    for (int i = 0; i < 4; i++) begin tot[i] = 5; plen[i] = 1; end
    drive_a();
    #1;
    repeat (10) cyc_a();
    check("rr_count", push_gid.size(), 5);
    for (int j = 0; j < 5 && j < push_gid.size(); j++) begin
      check($sformatf("rr_gid%0d", j), push_gid[j], exp_g3[j]);
      check($sformatf("rr_cyc%0d", j), push_cyc[j], exp_c3[j]);
    end
    if (push_data.size() > 4) check("rr_data4", push_data[4], 8'h01);
    check("rr_occ", a_occ, 5);

    // Requester 3 sends 20 beats without last: truncated after 16.
    for (int i = 0; i < 4; i++) begin tot[i] = 0; sent[i] = 0; end
    check("trunc_err_before", a_err_tr, 0);
    clear_log();
    lastmode[3] = 1'b0;
    tot[3] = 20;
    drive_a();
    #1;
    for (int k = 0; k < 40 && push_data.size() < 16; k++) cyc_a();
    check("trunc_count", push_data.size(), 16);
    if (push_data.size() > 15) check("trunc_last_data", push_data[15], 8'h3F);
    check("trunc_busy", a_busy, 0);
    check("trunc_err", a_err_tr, 1);
    check("trunc_occ", a_occ, 21);
    check("trunc_left", tot[3], 4);
    tot[0] = 1;
    drive_a();
    #1;
    cyc_a();
    check("trunc_next_grant", a_grant_id, 0);
    check("trunc_next_busy", a_busy, 1);
    for (int i = 0; i < 4; i++) tot[i] = 0;
    drive_a();

    // Instance B: 40-beat packet into a 31-entry buffer, pops admit one beat each.
    drive_b();
    #1;
    repeat (40) cyc_b();
    check("fill_acc", b_acc, 31);
    check("fill_occ", b_occ, 31);
    check("fill_ready", b_req_ready, 0);
    check("fill_busy", b_busy, 1);
    check("fill_grant", b_grant_id, 1);
    for (int p = 0; p < 9; p++) begin
      b_fifo_pop = 1'b1;
      cyc_b();
      b_fifo_pop = 1'b0;
      cyc_b();
      cyc_b();
      check($sformatf("pop_admit%0d", p), b_acc, 32 + p);
      check($sformatf("pop_occ%0d", p), b_occ, 31);
      check($sformatf("pop_grant%0d", p), b_grant_id, 1);
    end
    check("fill_done_busy", b_busy, 0);
    check("fill_err_tr", b_err_tr, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
